display_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for an N-digit 7-segment display. All digits

---
 rtl/display_scan_controller.sv | 218 +++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Purpose:
//   Time-multiplexed scan controller for an N-digit 7-segment display whose
//   digits share one 4-bit-input segment decoder. The block keeps a shadow copy
//   of the digit values. It steps through the digits one at a time and presents
//   the current digit's nibble to the decoder. It enables only that digit's
//   common line. A short all-dark gap comes before every digit so the previous
//   digit's segments do not ghost onto the next one.
//
//   New frames are loaded through a staging register. The shadow copy only
//   changes at a frame boundary, so a single scan frame never mixes old and new
//   digit values.
//
// Parameters:
//   N_DIGITS      number of digits scanned (>= 2)
//   REFRESH_DIV   clock cycles each digit is lit (>= 1)
//   BLANK_CYCLES  clock cycles all digits are dark before each digit (>= 1)
//
// Ports:
//   clk         in   1           rising-edge clock
//   rst         in   1           synchronous reset, active-high
//   enable      in   1           1 = scanning runs, 0 = display dark, scan parked
//   load        in   1           1-cycle strobe, capture data_in as a new frame
//   data_in     in   4*N_DIGITS  digit values, digit k = data_in[4k+3:4k]
//   blank_mask  in   N_DIGITS    1 = keep digit k dark during its lit slot
//   dec_nibble  out  4           nibble for the shared segment decoder
//   digit_en    out  N_DIGITS    one-hot active-high digit enable (0 = dark)
//   frame_done  out  1           1-cycle pulse on the first cycle after the
//                                last digit's lit slot
//   load_pend   out  1           a loaded frame is waiting for a frame boundary
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [3:0]            dec_nibble,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_done,
  output logic                  load_pend
);

  // One counter serves both the dark gap and the lit slot. Its width is the
  // larger of the two lengths. A minimum of one bit keeps the vector legal
  // when both lengths are 1.
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0   = N_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    wrap;

  logic [4*N_DIGITS-1:0]   shadow;
  logic [4*N_DIGITS-1:0]   shadow_nxt;
  logic [4*N_DIGITS-1:0]   staging;
  logic                    pending;
  logic                    pending_nxt;
  logic                    boundary;

  logic [3:0]              nibble_nxt;
  logic [N_DIGITS-1:0]     digit_en_nxt;

  // Scan state register: state, current digit index and in-state cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. Dropping enable overrides everything and parks the scan
  // at digit 0. This makes re-enabling always restart with a dark gap before
  // digit 0. 'wrap' marks the edge that leaves the last digit's lit slot. That
  // edge is the frame boundary while scanning.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end

        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Frame update. Outside a boundary, a load only fills staging and raises
  // pending. A later load simply overwrites staging. At a boundary the shadow
  // takes a same-edge load directly, or otherwise the waiting staged frame. In
  // both cases nothing is left pending. Every edge spent in IDLE counts as a
  // boundary, so a load made while parked takes effect at once.
  always_comb begin
    boundary    = wrap || (state == IDLE);
    shadow_nxt  = shadow;
    pending_nxt = pending;

    if (boundary) begin
      if (load) begin
        shadow_nxt = data_in;
      end else if (pending) begin
        shadow_nxt = staging;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // Output values for the coming cycle. They are derived from the next state
  // and the next shadow, so they are correct on the very first cycle of each
  // state. This includes the first dark cycle after a wrap that installed a new
  // frame. The masked digit still gets its nibble and timing. Only its enable
  // is suppressed.
  always_comb begin
    nibble_nxt   = 4'h0;
    digit_en_nxt = '0;

    if (state_nxt != IDLE) begin
      nibble_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
    end

    if (state_nxt == SHOW) begin
      digit_en_nxt = (ONE_HOT0 << idx_nxt) & ~blank_mask;
    end
  end

  // Frame storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      staging    <= '0;
      pending    <= 1'b0;
      dec_nibble <= 4'h0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        staging <= data_in;
      end
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      dec_nibble <= nibble_nxt;
      digit_en   <= digit_en_nxt;
      frame_done <= wrap;
    end
  end

  assign load_pend = pending;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Purpose:
//   Directed testbench for display_scan_controller with 4 digits, 4 lit cycles
//   and 2 dark cycles per digit. This gives a 24-cycle frame. Each scenario task
//   drives its own stimulus. It compares outputs against hand-derived
//   expectations and samples 1 time unit after the rising edge.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int N_DIGITS     = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = REFRESH_DIV + BLANK_CYCLES;
  localparam int FRAME        = N_DIGITS * SLOT;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_nibble;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        load_pend;

  int vec_count;
  int err_count;
  int pos;

  display_scan_controller #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .dec_nibble (dec_nibble),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .load_pend  (load_pend)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 unit past it. 'pos' tracks the
  // position within the 24-cycle frame once scanning runs.
  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    load       = 1'b0;
    data_in    = 16'h0000;
    blank_mask = 4'b0000;
    step();
    step();
    vec_count++;
    if (digit_en !== 4'b0000) begin
      err_count++;
      $display("[TB] FAIL reset_digit_en: got %b expected %b", digit_en, 4'b0000);
    end
    vec_count++;
    if (dec_nibble !== 4'h0) begin
      err_count++;
      $display("[TB] FAIL reset_dec_nibble: got %h expected %h", dec_nibble, 4'h0);
    end
    vec_count++;
    if (frame_done !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL reset_frame_done: got %b expected %b", frame_done, 1'b0);
    end
    vec_count++;
    if (load_pend !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL reset_load_pend: got %b expected %b", load_pend, 1'b0);
    end
    rst    = 1'b0;
    enable = 1'b0;
    step();
  endtask

  // Load 4321 while parked, then scan two full frames.
  task automatic test_scan_order();
    logic [3:0] exp_en;
    logic [3:0] exp_nib;
    logic       exp_fd;
    int         d;
    load    = 1'b1;
    data_in = 16'h4321;
    step();
    load = 1'b0;
    vec_count++;
    if (load_pend !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL idle_load_pend: got %b expected %b", load_pend, 1'b0);
    end
    enable = 1'b1;
    pos    = FRAME - 1;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      step();
      d       = pos / SLOT;
      exp_en  = ((pos % SLOT) >= BLANK_CYCLES) ? (4'b0001 << d) : 4'b0000;
      exp_nib = 4'(d + 1);
      exp_fd  = (pos == 0) && (n > 1);
      vec_count++;
      if (digit_en !== exp_en) begin
        err_count++;
        $display("[TB] FAIL scan_digit_en at pos %0d: got %b expected %b", pos, digit_en, exp_en);
      end
      vec_count++;
      if (dec_nibble !== exp_nib) begin
        err_count++;
        $display("[TB] FAIL scan_dec_nibble at pos %0d: got %h expected %h", pos, dec_nibble, exp_nib);
      end
      vec_count++;
      if (frame_done !== exp_fd) begin
        err_count++;
        $display("[TB] FAIL scan_frame_done at pos %0d: got %b expected %b", pos, frame_done, exp_fd);
      end
    end
  endtask

  // Load 8765 during digit 1's lit slot. The current frame stays 1..4. The
  // next frame shows 5..8.
  task automatic test_tear_free();
    logic [3:0] exp_nib;
    while (pos != 10) step();
    load    = 1'b1;
    data_in = 16'h8765;
    step();
    load = 1'b0;
    vec_count++;
    if (load_pend !== 1'b1) begin
      err_count++;
      $display("[TB] FAIL tear_load_pend_set: got %b expected %b", load_pend, 1'b1);
    end
    while (pos != FRAME - 1) begin
      step();
      exp_nib = 4'(pos / SLOT + 1);
      vec_count++;
      if (dec_nibble !== exp_nib || load_pend !== 1'b1) begin
        err_count++;
        $display("[TB] FAIL tear_old_frame at pos %0d: got nibble %h pend %b expected nibble %h pend 1",
                 pos, dec_nibble, load_pend, exp_nib);
      end
    end
    for (int n = 0; n < FRAME; n++) begin
      step();
      exp_nib = 4'(pos / SLOT + 5);
      vec_count++;
      if (dec_nibble !== exp_nib || load_pend !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL tear_new_frame at pos %0d: got nibble %h pend %b expected nibble %h pend 0",
                 pos, dec_nibble, load_pend, exp_nib);
      end
      if (pos == 0) begin
        vec_count++;
        if (frame_done !== 1'b1) begin
          err_count++;
          $display("[TB] FAIL tear_wrap_frame_done: got %b expected %b", frame_done, 1'b1);
        end
      end
    end
  endtask

  // Load 0F0F exactly on the wrap edge. It goes straight to shadow and
  // nothing is left pending.
  task automatic test_load_on_wrap();
    logic [3:0] exp_nib;
    while (pos != FRAME - 1) step();
    load    = 1'b1;
    data_in = 16'h0F0F;
    step();
    load = 1'b0;
    for (int n = 0; n < FRAME; n++) begin
      exp_nib = ((pos / SLOT) % 2 == 0) ? 4'hF : 4'h0;
      vec_count++;
      if (dec_nibble !== exp_nib || load_pend !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL wrap_load at pos %0d: got nibble %h pend %b expected nibble %h pend 0",
                 pos, dec_nibble, load_pend, exp_nib);
      end
      if (n < FRAME - 1) step();
    end
  endtask

  // Mask digit 2. Its lit slot stays dark but keeps its nibble and timing.
  task automatic test_blank_mask();
    logic [3:0] exp_en;
    logic [3:0] exp_nib;
    logic       exp_fd;
    int         d;
    blank_mask = 4'b0100;
    for (int n = 0; n < FRAME; n++) begin
      step();
      d       = pos / SLOT;
      exp_en  = ((pos % SLOT) >= BLANK_CYCLES) ? ((4'b0001 << d) & 4'b1011) : 4'b0000;
      exp_nib = (d % 2 == 0) ? 4'hF : 4'h0;
      exp_fd  = (pos == 0);
      vec_count++;
      if (digit_en !== exp_en || dec_nibble !== exp_nib || frame_done !== exp_fd) begin
        err_count++;
        $display("[TB] FAIL mask_slot at pos %0d: got en %b nib %h fd %b expected en %b nib %h fd %b",
                 pos, digit_en, dec_nibble, frame_done, exp_en, exp_nib, exp_fd);
      end
    end
    blank_mask = 4'b0000;
  endtask

  // Drop enable mid-lit of digit 2, load while parked, re-enable.
  task automatic test_enable_drop();
    while (pos != 15) step();
    enable = 1'b0;
    step();
    vec_count++;
    if (digit_en !== 4'b0000 || frame_done !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL drop_dark: got en %b fd %b expected en 0000 fd 0", digit_en, frame_done);
    end
    load    = 1'b1;
    data_in = 16'hABCD;
    step();
    load = 1'b0;
    vec_count++;
    if (load_pend !== 1'b0 || digit_en !== 4'b0000) begin
      err_count++;
      $display("[TB] FAIL idle_load_immediate: got pend %b en %b expected pend 0 en 0000", load_pend, digit_en);
    end
    enable = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      vec_count++;
      if (digit_en !== 4'b0000 || dec_nibble !== 4'hD) begin
        err_count++;
        $display("[TB] FAIL restart_blank %0d: got en %b nib %h expected en 0000 nib d", n, digit_en, dec_nibble);
      end
    end
    for (int n = 0; n < REFRESH_DIV; n++) begin
      step();
      vec_count++;
      if (digit_en !== 4'b0001 || dec_nibble !== 4'hD) begin
        err_count++;
        $display("[TB] FAIL restart_digit0 %0d: got en %b nib %h expected en 0001 nib d", n, digit_en, dec_nibble);
      end
    end
    step();
    vec_count++;
    if (digit_en !== 4'b0000 || dec_nibble !== 4'hC) begin
      err_count++;
      $display("[TB] FAIL restart_digit1_blank: got en %b nib %h expected en 0000 nib c", digit_en, dec_nibble);
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    pos       = 0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_load_on_wrap();
    test_blank_mask();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
